// File: rtl/guess_round_ctrl.sv
// Round sequencer for the four-digit guess-number game.
// Collects keypad digits into a guess and refuses repeated digits. On enter it
// strobes a compare into the match datapath and latches the A/B result. It
// counts attempts and declares win or loss.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                pulse: begin or restart a game
//   key_valid, key_code  decoded key press (0-9 digit, A backspace, B enter)
//   r_a, r_b             match result, valid MATCH_LAT cycles after match_req
//   guess, digit_cnt     entered digits (first in [15:12], unused F) and count
//   match_req            one-cycle compare strobe
//   last_a, last_b       latched result of the most recent compare
//   attempts             completed compares this game
//   phase                0 IDLE, 1 ENTRY, 2 CHECK, 3 WAIT, 4 WIN, 5 LOSE
//   key_reject           one-cycle pulse when a key press is refused
module guess_round_ctrl #(
    parameter int unsigned MAX_TRIES = 10,
    parameter int unsigned MATCH_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [2:0]  r_a,
    input  logic [2:0]  r_b,
    output logic [15:0] guess,
    output logic [2:0]  digit_cnt,
    output logic        match_req,
    output logic [2:0]  last_a,
    output logic [2:0]  last_b,
    output logic [3:0]  attempts,
    output logic [2:0]  phase,
    output logic        key_reject
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_CHECK = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WIN   = 3'd4,
        ST_LOSE  = 3'd5
    } state_t;

    localparam logic [3:0] KEY_BKSP  = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    state_t      state_q, state_d;
    logic [15:0] guess_q, guess_d;
    logic [2:0]  digit_cnt_q, digit_cnt_d;
    logic        match_req_q, match_req_d;
    logic [2:0]  last_a_q, last_a_d;
    logic [2:0]  last_b_q, last_b_d;
    logic [3:0]  attempts_q, attempts_d;
    logic        key_reject_q, key_reject_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic        start_pend_q, start_pend_d;

    logic        is_digit;
    logic        dup;
    logic [3:0]  attempts_inc;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            guess_q      <= 16'hFFFF;
            digit_cnt_q  <= 3'd0;
            match_req_q  <= 1'b0;
            last_a_q     <= 3'd0;
            last_b_q     <= 3'd0;
            attempts_q   <= 4'd0;
            key_reject_q <= 1'b0;
            wait_cnt_q   <= 3'd0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            guess_q      <= guess_d;
            digit_cnt_q  <= digit_cnt_d;
            match_req_q  <= match_req_d;
            last_a_q     <= last_a_d;
            last_b_q     <= last_b_d;
            attempts_q   <= attempts_d;
            key_reject_q <= key_reject_d;
            wait_cnt_q   <= wait_cnt_d;
            start_pend_q <= start_pend_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        guess_d      = guess_q;
        digit_cnt_d  = digit_cnt_q;
        last_a_d     = last_a_q;
        last_b_d     = last_b_q;
        attempts_d   = attempts_q;
        key_reject_d = 1'b0;
        wait_cnt_d   = wait_cnt_q;
        start_pend_d = start_pend_q;

        is_digit     = (key_code <= 4'd9);
        attempts_inc = (attempts_q == 4'd15) ? 4'd15 : attempts_q + 4'd1;

        // Only the nibbles already written take part in the repeat check
        dup = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) < digit_cnt_q) && (guess_q[15-4*i -: 4] == key_code)) begin
                dup = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_ENTRY, ST_WIN, ST_LOSE: begin
                if (start) begin
                    // Start beats any key in the same cycle; that key is dropped silently
                    state_d     = ST_ENTRY;
                    guess_d     = 16'hFFFF;
                    digit_cnt_d = 3'd0;
                    attempts_d  = 4'd0;
                    last_a_d    = 3'd0;
                    last_b_d    = 3'd0;
                end else if (key_valid && (state_q == ST_WIN || state_q == ST_LOSE)) begin
                    key_reject_d = 1'b1;
                end else if (key_valid && state_q == ST_ENTRY) begin
                    if (is_digit) begin
                        if (digit_cnt_q < 3'd4 && !dup) begin
                            for (int i = 0; i < 4; i++) begin
                                if (3'(i) == digit_cnt_q) guess_d[15-4*i -: 4] = key_code;
                            end
                            digit_cnt_d = digit_cnt_q + 3'd1;
                        end else begin
                            key_reject_d = 1'b1;
                        end
                    end else if (key_code == KEY_BKSP) begin
                        if (digit_cnt_q != 3'd0) begin
                            for (int i = 0; i < 4; i++) begin
                                if (3'(i) == digit_cnt_q - 3'd1) guess_d[15-4*i -: 4] = 4'hF;
                            end
                            digit_cnt_d = digit_cnt_q - 3'd1;
                        end else begin
                            key_reject_d = 1'b1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        if (digit_cnt_q == 3'd4) state_d = ST_CHECK;
                        else key_reject_d = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                state_d    = ST_WAIT;
                wait_cnt_d = 3'(MATCH_LAT - 1);
                if (start) start_pend_d = 1'b1;
            end
            ST_WAIT: begin
                if (start) start_pend_d = 1'b1;
                if (wait_cnt_q == 3'd0) begin
                    last_a_d     = r_a;
                    last_b_d     = r_b;
                    attempts_d   = attempts_inc;
                    guess_d      = 16'hFFFF;
                    digit_cnt_d  = 3'd0;
                    start_pend_d = 1'b0;
                    // A deferred restart overrides the outcome but keeps the latched result
                    if (start_pend_q || start) begin
                        state_d    = ST_ENTRY;
                        attempts_d = 4'd0;
                    end else if (r_a == 3'd4) begin
                        state_d = ST_WIN;
                        guess_d = guess_q;
                        digit_cnt_d = digit_cnt_q;
                    end else if (attempts_inc == 4'(MAX_TRIES)) begin
                        state_d = ST_LOSE;
                        guess_d = guess_q;
                        digit_cnt_d = digit_cnt_q;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        match_req_d = (state_d == ST_CHECK);
    end

    assign guess      = guess_q;
    assign digit_cnt  = digit_cnt_q;
    assign match_req  = match_req_q;
    assign last_a     = last_a_q;
    assign last_b     = last_b_q;
    assign attempts   = attempts_q;
    assign phase      = state_q;
    assign key_reject = key_reject_q;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed bench for guess_round_ctrl (MAX_TRIES=3, MATCH_LAT=2).
module tb_guess_round_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [2:0]  r_a;
    logic [2:0]  r_b;
    logic [15:0] guess;
    logic [2:0]  digit_cnt;
    logic        match_req;
    logic [2:0]  last_a;
    logic [2:0]  last_b;
    logic [3:0]  attempts;
    logic [2:0]  phase;
    logic        key_reject;

    int n_vec = 0;
    int n_err = 0;

    guess_round_ctrl #(.MAX_TRIES(3), .MATCH_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
        .key_code(key_code), .r_a(r_a), .r_b(r_b), .guess(guess),
        .digit_cnt(digit_cnt), .match_req(match_req), .last_a(last_a),
        .last_b(last_b), .attempts(attempts), .phase(phase),
        .key_reject(key_reject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        step();
        key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Four digits, enter, then run the three cycles until the result lands
    task automatic full_guess(input logic [15:0] g);
        logic [15:0] gv;
        gv = g;
        for (int i = 0; i < 4; i++) press(gv[15-4*i -: 4]);
        press(4'hB);
        step();
        step();
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        r_a = 3'd0; r_b = 3'd0;
        step();
        chk("rst_phase", 16'(phase), 16'd0);
        chk("rst_guess", guess, 16'hFFFF);
        chk("rst_attempts", 16'(attempts), 16'd0);
        chk("rst_mreq", 16'(match_req), 16'd0);
        rst = 1'b0;
        step();

        // Keys are ignored in IDLE
        press(4'd1);
        chk("idle_key_rej", 16'(key_reject), 16'd0);
        chk("idle_key_cnt", 16'(digit_cnt), 16'd0);

        // Winning first guess 1234
        pulse_start();
        chk("start_phase", 16'(phase), 16'd1);
        for (int i = 1; i <= 4; i++) press(4'(i));
        chk("win_guess", guess, 16'h1234);
        chk("win_cnt", 16'(digit_cnt), 16'd4);
        r_a = 3'd4; r_b = 3'd0;
        press(4'hB);
        chk("win_check_phase", 16'(phase), 16'd2);
        chk("win_mreq1", 16'(match_req), 16'd1);
        chk("win_mreq_guess", guess, 16'h1234);
        step();
        chk("win_wait_phase", 16'(phase), 16'd3);
        chk("win_mreq2", 16'(match_req), 16'd0);
        step();
        chk("win_wait2_phase", 16'(phase), 16'd3);
        chk("win_wait2_att", 16'(attempts), 16'd0);
        step();
        chk("win_phase", 16'(phase), 16'd4);
        chk("win_last_a", 16'(last_a), 16'd4);
        chk("win_attempts", 16'(attempts), 16'd1);
        chk("win_mreq3", 16'(match_req), 16'd0);
        press(4'd5);
        chk("win_key_rej", 16'(key_reject), 16'd1);
        chk("win_hold_guess", guess, 16'h1234);

        // Duplicate, early enter, backspace
        pulse_start();
        chk("restart_att", 16'(attempts), 16'd0);
        chk("restart_last_a", 16'(last_a), 16'd0);
        press(4'd5);
        press(4'd5);
        chk("dup_rej", 16'(key_reject), 16'd1);
        chk("dup_cnt", 16'(digit_cnt), 16'd1);
        step();
        chk("dup_rej_pulse", 16'(key_reject), 16'd0);
        press(4'd6);
        press(4'd7);
        press(4'hB);
        chk("early_enter_rej", 16'(key_reject), 16'd1);
        chk("early_enter_phase", 16'(phase), 16'd1);
        press(4'hA);
        chk("bksp_guess", guess, 16'h56FF);
        chk("bksp_cnt", 16'(digit_cnt), 16'd2);
        press(4'd8);
        press(4'd9);
        chk("edit_guess", guess, 16'h5689);

        // Three misses reach LOSE
        r_a = 3'd1; r_b = 3'd2;
        press(4'hB);
        step(); step(); step();
        chk("miss1_phase", 16'(phase), 16'd1);
        chk("miss1_att", 16'(attempts), 16'd1);
        chk("miss1_guess", guess, 16'hFFFF);
        full_guess(16'h1234);
        chk("miss2_att", 16'(attempts), 16'd2);
        full_guess(16'h9876);
        chk("lose_phase", 16'(phase), 16'd5);
        chk("lose_att", 16'(attempts), 16'd3);
        chk("lose_a", 16'(last_a), 16'd1);
        chk("lose_b", 16'(last_b), 16'd2);
        press(4'd1);
        chk("lose_key_rej", 16'(key_reject), 16'd1);
        pulse_start();
        chk("lose_restart_phase", 16'(phase), 16'd1);
        chk("lose_restart_att", 16'(attempts), 16'd0);

        // Re-enter a digit after backspacing it; zero-count backspace
        press(4'hA);
        chk("bksp_empty_rej", 16'(key_reject), 16'd1);
        press(4'd3);
        press(4'hA);
        press(4'd3);
        chk("reenter_guess", guess, 16'h3FFF);
        chk("reenter_rej", 16'(key_reject), 16'd0);

        // start during WAIT defers past a winning result
        press(4'd1); press(4'd2); press(4'd4);
        r_a = 3'd4; r_b = 3'd0;
        press(4'hB);
        step();
        chk("defer_wait_phase", 16'(phase), 16'd3);
        pulse_start();
        chk("defer_still_wait", 16'(phase), 16'd3);
        step();
        chk("defer_phase", 16'(phase), 16'd1);
        chk("defer_last_a", 16'(last_a), 16'd4);
        chk("defer_att", 16'(attempts), 16'd0);
        chk("defer_guess", guess, 16'hFFFF);

        // Fifth digit refused; start beats a same-cycle key
        for (int i = 5; i <= 8; i++) press(4'(i));
        press(4'd9);
        chk("fifth_rej", 16'(key_reject), 16'd1);
        chk("fifth_guess", guess, 16'h5678);
        start = 1'b1;
        press(4'd7);
        start = 1'b0;
        chk("sk_phase", 16'(phase), 16'd1);
        chk("sk_cnt", 16'(digit_cnt), 16'd0);
        chk("sk_rej", 16'(key_reject), 16'd0);
        chk("sk_guess", guess, 16'hFFFF);

        // Asynchronous reset in WAIT with attempts nonzero
        r_a = 3'd0;
        full_guess(16'h1357);
        chk("pre_rst_att", 16'(attempts), 16'd1);
        for (int i = 0; i < 4; i++) press(4'(i));
        press(4'hB);
        step();
        chk("pre_rst_phase", 16'(phase), 16'd3);
        rst = 1'b1;
        #1;
        chk("arst_phase", 16'(phase), 16'd0);
        chk("arst_guess", guess, 16'hFFFF);
        chk("arst_att", 16'(attempts), 16'd0);
        chk("arst_mreq", 16'(match_req), 16'd0);
        step();
        rst = 1'b0;
        step(); step();
        chk("post_rst_phase", 16'(phase), 16'd0);
        chk("post_rst_guess", guess, 16'hFFFF);
        chk("post_rst_att", 16'(attempts), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/guess_round_ctrl.md
Name: guess_round_ctrl

Overview:
Sequences one round of the four-digit guess-number game. It collects decoded keypad digits into a guess register and rejects repeated digits. On enter it launches a compare against the secret in the match datapath, then latches the A/B result. It counts attempts, declares win or loss, and drives phase and status outputs for the seven-segment and dot-matrix display blocks.

Parameters:
MAX_TRIES, 10, attempts allowed before LOSE (1..15)
MATCH_LAT, 2, cycles from match_req to valid r_a/r_b (1..7)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle pulse; begins or restarts a game
key_valid  input  1  single-cycle pulse, one per debounced key press
key_code  input  4  0-9 digit, 4'hA backspace, 4'hB enter, others ignored
r_a  input  3  match result: right digit, right place
r_b  input  3  match result: right digit, wrong place
guess  output  16  entered digits; first digit in [15:12], last in [3:0], unused nibbles 4'hF
digit_cnt  output  3  digits entered (0..4)
match_req  output  1  one-cycle compare strobe; guess is stable while it is high and until the result is sampled
last_a  output  3  latched A of most recent compare
last_b  output  3  latched B of most recent compare
attempts  output  4  completed compares this game
phase  output  3  0 IDLE, 1 ENTRY, 2 CHECK, 3 WAIT, 4 WIN, 5 LOSE
key_reject  output  1  one-cycle pulse when a key press is refused

Behaviour:
- Reset (async, any state): phase=IDLE, guess=16'hFFFF, digit_cnt=0, attempts=0, last_a=0, last_b=0, match_req=0, key_reject=0.
- IDLE: keys ignored with no reject; start -> ENTRY.
- ENTRY, key_valid with digit d (0-9):
  - digit_cnt<4 and d not already in guess: write d to nibble index digit_cnt; digit_cnt+1; visible next cycle.
  - digit_cnt==4 or d is a duplicate: no change; key_reject=1 next cycle.
- ENTRY, backspace: if digit_cnt>0, set last written nibble to F and digit_cnt-1; else key_reject.
- ENTRY, enter: if digit_cnt==4, go to CHECK; else key_reject.
- ENTRY, other codes: ignored, no reject.
- CHECK: lasts exactly one cycle with match_req=1, then WAIT.
- WAIT: a down-counter is loaded with MATCH_LAT-1. On the cycle the counter reaches 0:
  - latch last_a=r_a and last_b=r_b; attempts+1 (saturating at 15).
  - if r_a==4: go to WIN.
  - else if the incremented attempts==MAX_TRIES: go to LOSE.
  - else: go to ENTRY with guess=FFFF and digit_cnt=0.
- Total latency from enter press to the updated last_a/attempts is MATCH_LAT+1 cycles after the enter key_valid.
- Keys during CHECK/WAIT: ignored, no reject. start during CHECK/WAIT is deferred: it takes effect on the cycle WAIT resolves, overriding the outcome transition; the result is still latched.
- WIN/LOSE: hold all outputs. Keys get key_reject. start -> ENTRY.
- start in ENTRY, WIN, LOSE or IDLE: next cycle phase=ENTRY, guess=FFFF, digit_cnt=0, attempts=0, last_a=last_b=0.
- start and key_valid in the same cycle: start wins and the key is dropped without reject.
- Boundaries:
  - r_a==4 on the attempt that reaches MAX_TRIES -> WIN. Win takes priority over lose.
  - Backspace then re-enter of the same digit is accepted.
  - Duplicate check covers only the first digit_cnt nibbles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset mid-WAIT -> phase=0, guess=FFFF, attempts=0 and match_req low on the same cycle rst rises; all hold after rst falls.
- start, keys 1,2,3,4, enter; r_a=4, r_b=0 with MATCH_LAT=2 -> guess=16'h1234, single match_req pulse, WIN 3 cycles after enter, last_a=4, attempts=1.
- start, keys 5,5 -> second 5 gives key_reject pulse, digit_cnt=1. Then 6,7, enter -> key_reject, phase stays ENTRY. Then backspace, 8, 9 -> guess=16'h5689.
- MAX_TRIES=3, three guesses returning r_a=1, r_b=2 -> attempts=3, phase=LOSE, last_a=1, last_b=2. A key press -> key_reject; start -> ENTRY, attempts=0.
- start pulse during WAIT, with the result r_a=4 -> result latched, then phase=ENTRY (not WIN), attempts=0.
- Fifth digit after four entered -> key_reject, guess unchanged. start and key_valid=7 in the same cycle -> ENTRY, digit_cnt=0, no reject.
